// File: rtl/add_result_pkg.sv
// Shared types and helpers for the adder result FIFO slice.
package add_result_pkg;

   localparam int unsigned ADD_DATA_W = 32;
   localparam int unsigned MAX_CNT_W  = 32;

   typedef struct packed {
      logic                  of;
      logic [ADD_DATA_W-1:0] sum;
   } entry_t;

   typedef enum logic [1:0] {
      StEmpty,
      StPartial,
      StFull
   } fifo_state_e;

   // Saturating increment for a counter of width w (w <= MAX_CNT_W), held zero-extended.
   function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] v,
                                                   input int unsigned w);
      logic [MAX_CNT_W-1:0] lim;
      if (w >= MAX_CNT_W) begin
         lim = '1;
      end else begin
         lim = (MAX_CNT_W'(1) << w) - MAX_CNT_W'(1);
      end
      return (v >= lim) ? lim : v + MAX_CNT_W'(1);
   endfunction

endpackage

// File: rtl/add_result_ram.sv
// DEPTH x (DATA_W+1) register array: one synchronous write port, combinational read.
module add_result_ram
   import add_result_pkg::*;
#(
   parameter int unsigned DATA_W = ADD_DATA_W,
   parameter int unsigned DEPTH  = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [PTR_W-1:0] wr_addr,
   input  logic [DATA_W:0]  wr_data,
   input  logic [PTR_W-1:0] rd_addr,
   output logic [DATA_W:0]  rd_data
);

   logic [DATA_W:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/add_result_fifo.sv
// Captures {overflow, sum} adder results into a FIFO with valid/ready output and statistics.
// Optional macro ADD_RESULT_OF_FILTER_EN: overflow results are consumed instead of stored.
module add_result_fifo
   import add_result_pkg::*;
#(
   parameter int unsigned DATA_W = ADD_DATA_W,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned CNT_W  = 16,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
   input  logic              outclk_0,
   input  logic              rst,
   input  logic              locked,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_sum,
   input  logic              in_of,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_sum,
   output logic              out_of,
   input  logic              out_ready,
   output logic [LVL_W-1:0]  level,
   output logic [CNT_W-1:0]  of_cnt,
   output logic [CNT_W-1:0]  drop_cnt
);

   localparam logic [LVL_W-1:0] FullLvl = LVL_W'(DEPTH);

   logic              eff_rst;
   logic              push;
   logic              pop;
   logic              of_inc;
   logic              drop_inc;
   logic [DATA_W:0]   wr_data;
   logic [DATA_W:0]   rd_data;
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [LVL_W-1:0]  level_q;
   logic [LVL_W-1:0]  level_d;
   fifo_state_e       state_q;
   fifo_state_e       state_d;
   logic              in_ready_q;
   logic [CNT_W-1:0]  of_cnt_q;
   logic [CNT_W-1:0]  drop_cnt_q;

   always_comb begin
      eff_rst = rst || !locked;
      pop     = (state_q != StEmpty) && out_ready;
`ifdef ADD_RESULT_OF_FILTER_EN
      // Overflow results never occupy an entry and are never counted as drops.
      push     = in_valid && in_ready_q && !in_of && !eff_rst;
      of_inc   = in_valid && in_of;
      drop_inc = in_valid && !in_ready_q && !in_of;
      wr_data  = {1'b0, in_sum};
`else
      push     = in_valid && in_ready_q && !eff_rst;
      of_inc   = push && in_of;
      drop_inc = in_valid && !in_ready_q;
      wr_data  = {in_of, in_sum};
`endif
   end

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
      state_d = StPartial;
      if (level_d == '0) begin
         state_d = StEmpty;
      end else if (level_d == FullLvl) begin
         state_d = StFull;
      end
   end

   // Reset takes priority over any push/pop presented in the same cycle.
   always_ff @(posedge outclk_0) begin
      if (eff_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         state_q    <= StEmpty;
         in_ready_q <= 1'b0;
         of_cnt_q   <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         level_q    <= level_d;
         state_q    <= state_d;
         in_ready_q <= (state_d != StFull);
         if (of_inc) begin
            of_cnt_q <= CNT_W'(sat_inc(MAX_CNT_W'(of_cnt_q), CNT_W));
         end
         if (drop_inc) begin
            drop_cnt_q <= CNT_W'(sat_inc(MAX_CNT_W'(drop_cnt_q), CNT_W));
         end
      end
   end

   add_result_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (outclk_0),
      .wr_en   (push),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_data),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != StEmpty);
   assign out_sum   = rd_data[DATA_W-1:0];
`ifdef ADD_RESULT_OF_FILTER_EN
   assign out_of    = 1'b0;
`else
   assign out_of    = rd_data[DATA_W];
`endif
   assign level     = level_q;
   assign of_cnt    = of_cnt_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_add_result_fifo.sv
// Bench for add_result_fifo: directed table, corner sequences and random traffic vs a queue model.
module tb_add_result_fifo;

   localparam int unsigned DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        locked = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_sum = '0;
   logic        in_of = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, out_of;
   logic [31:0] out_sum;
   logic [3:0]  level;
   logic [15:0] of_cnt, drop_cnt;

   logic        s_in_ready, s_out_valid, s_out_of;
   logic [31:0] s_out_sum;
   logic [3:0]  s_level;
   logic [3:0]  s_of_cnt, s_drop_cnt;

   int unsigned total = 0;
   int unsigned bad = 0;

   // Reference model state
   logic [32:0] mq[$];
   bit          m_rdy = 1'b0;
   int unsigned m_ofc = 0;
   int unsigned m_drop = 0;

   always #5 clk = ~clk;

   add_result_fifo #(.DATA_W(32), .DEPTH(DEPTH), .CNT_W(16)) dut (
      .outclk_0 (clk),       .rst (rst),           .locked (locked),
      .in_valid (in_valid),  .in_sum (in_sum),     .in_of (in_of),
      .in_ready (in_ready),  .out_valid (out_valid), .out_sum (out_sum),
      .out_of (out_of),      .out_ready (out_ready), .level (level),
      .of_cnt (of_cnt),      .drop_cnt (drop_cnt)
   );

   add_result_fifo #(.DATA_W(32), .DEPTH(DEPTH), .CNT_W(4)) dut_sat (
      .outclk_0 (clk),         .rst (rst),             .locked (locked),
      .in_valid (in_valid),    .in_sum (in_sum),       .in_of (in_of),
      .in_ready (s_in_ready),  .out_valid (s_out_valid), .out_sum (s_out_sum),
      .out_of (s_out_of),      .out_ready (out_ready), .level (s_level),
      .of_cnt (s_of_cnt),      .drop_cnt (s_drop_cnt)
   );

   task automatic chk(input string tag, input string what, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s.%s: got %0h expected %0h", tag, what, act, exp);
      end
   endtask

   function automatic int unsigned satv(input int unsigned v, input int unsigned lim);
      return (v > lim) ? lim : v;
   endfunction

   // Model of one clock edge, using the inputs presented before that edge.
   task automatic model_step();
      bit pop_m;
      bit acc;
      if (rst || !locked) begin
         mq.delete();
         m_rdy  = 1'b0;
         m_ofc  = 0;
         m_drop = 0;
      end else begin
         pop_m = (mq.size() != 0) && out_ready;
         acc   = in_valid && m_rdy;
         if (pop_m) void'(mq.pop_front());
`ifdef ADD_RESULT_OF_FILTER_EN
         if (in_valid && in_of) m_ofc++;
         else if (acc) mq.push_back({1'b0, in_sum});
         else if (in_valid) m_drop++;
`else
         if (acc) begin
            mq.push_back({in_of, in_sum});
            if (in_of) m_ofc++;
         end else if (in_valid) begin
            m_drop++;
         end
`endif
         m_rdy = (mq.size() < DEPTH);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic check_model(input string tag);
      chk(tag, "out_valid", out_valid, mq.size() != 0);
      chk(tag, "level", level, mq.size());
      chk(tag, "in_ready", in_ready, m_rdy);
      chk(tag, "of_cnt", of_cnt, satv(m_ofc, 16'hFFFF));
      chk(tag, "drop_cnt", drop_cnt, satv(m_drop, 16'hFFFF));
      chk(tag, "sat_of_cnt", s_of_cnt, satv(m_ofc, 15));
      chk(tag, "sat_drop_cnt", s_drop_cnt, satv(m_drop, 15));
      if (mq.size() != 0) begin
         chk(tag, "out_sum", out_sum, mq[0][31:0]);
         chk(tag, "out_of", out_of, mq[0][32]);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; locked = 1'b1; in_valid = 1'b0; in_of = 1'b0; out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   typedef struct {
      logic        rst, locked, iv;
      logic [31:0] sum;
      logic        of, ordy;
      logic        e_valid;
      logic [31:0] e_sum;
      logic        e_of;
      logic [3:0]  e_level;
      logic        e_rdy;
      logic [15:0] e_ofc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic lk, input logic iv, input logic [31:0] s,
                               input logic o, input logic ordy, input logic ev,
                               input logic [31:0] es, input logic eo, input logic [3:0] el,
                               input logic er, input logic [15:0] eofc);
      vec_t v;
      v.rst = r; v.locked = lk; v.iv = iv; v.sum = s; v.of = o; v.ordy = ordy;
      v.e_valid = ev; v.e_sum = es; v.e_of = eo; v.e_level = el; v.e_rdy = er; v.e_ofc = eofc;
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Directed single-result and overflow rows.
      tbl.push_back(mk(1, 1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, 1, 32'h5, 0, 0, 1, 32'h5, 0, 1, 1, 0));
      tbl.push_back(mk(0, 1, 0, 32'h0, 0, 0, 1, 32'h5, 0, 1, 1, 0));
      tbl.push_back(mk(0, 1, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 1, 0));
`ifdef ADD_RESULT_OF_FILTER_EN
      tbl.push_back(mk(0, 1, 1, 32'h7FFF_FFFF, 1, 0, 0, 32'h0, 0, 0, 1, 1));
`else
      tbl.push_back(mk(0, 1, 1, 32'h7FFF_FFFF, 1, 0, 1, 32'h7FFF_FFFF, 1, 1, 1, 1));
`endif
      tbl.push_back(mk(0, 1, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 1, 1));
      tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].rst; locked = tbl[i].locked; in_valid = tbl[i].iv;
         in_sum = tbl[i].sum; in_of = tbl[i].of; out_ready = tbl[i].ordy;
         tick();
         chk($sformatf("vec%0d", i), "out_valid", out_valid, tbl[i].e_valid);
         chk($sformatf("vec%0d", i), "level", level, tbl[i].e_level);
         chk($sformatf("vec%0d", i), "in_ready", in_ready, tbl[i].e_rdy);
         chk($sformatf("vec%0d", i), "of_cnt", of_cnt, tbl[i].e_ofc);
         if (tbl[i].e_valid) begin
            chk($sformatf("vec%0d", i), "out_sum", out_sum, tbl[i].e_sum);
            chk($sformatf("vec%0d", i), "out_of", out_of, tbl[i].e_of);
         end
         check_model($sformatf("vec%0d_m", i));
      end

      // Fill past full, then drain in order.
      do_reset();
      for (int i = 1; i <= 10; i++) begin
         in_valid = 1'b1; in_sum = 32'(i); in_of = 1'b0;
         tick();
         check_model("fill");
      end
      in_valid = 1'b0;
      chk("fill", "level", level, 8);
      chk("fill", "in_ready", in_ready, 0);
      chk("fill", "drop_cnt", drop_cnt, 2);
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         chk("drain", "out_valid", out_valid, 1);
         chk("drain", "out_sum", out_sum, 32'(i));
         tick();
         check_model("drain");
      end
      chk("drain", "empty", out_valid, 0);

      // Steady push+pop at level 4 across pointer wrap.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_sum = 32'(100 + i);
         tick();
      end
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         in_sum = 32'(104 + k);
         chk("wrap", "out_sum", out_sum, 32'(100 + k));
         tick();
         chk("wrap", "level", level, 4);
         check_model("wrap");
      end

      // Lock loss mid-traffic, with push and pop presented in the same cycle.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_sum = 32'(200 + i); in_of = (i == 0);
         tick();
      end
      in_of = 1'b0;
      check_model("prelock");
      locked = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
      tick();
      chk("lock", "level", level, 0);
      chk("lock", "out_valid", out_valid, 0);
      chk("lock", "in_ready", in_ready, 0);
      chk("lock", "of_cnt", of_cnt, 0);
      chk("lock", "drop_cnt", drop_cnt, 0);
      locked = 1'b1; in_valid = 1'b0;
      tick();
      chk("relock", "in_ready", in_ready, 1);
      check_model("relock");

      // Saturation of the 4-bit instance.
      do_reset();
      in_valid = 1'b1; in_of = 1'b0;
      for (int i = 0; i < 28; i++) begin
         in_sum = 32'(i);
         tick();
         check_model("sat");
      end
      chk("sat", "sat_drop_cnt", s_drop_cnt, 4'hF);
      chk("sat", "drop_cnt", drop_cnt, 20);
      for (int i = 0; i < 3; i++) tick();
      chk("sat_hold", "sat_drop_cnt", s_drop_cnt, 4'hF);
      chk("sat_hold", "drop_cnt", drop_cnt, 23);

      // Random traffic in phases with different fill/drain bias.
      do_reset();
      for (int p = 0; p < 4; p++) begin
         for (int c = 0; c < 700; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            locked    = ($urandom_range(0, 399) != 0);
            in_valid  = ($urandom_range(0, 3) <= (p == 1 ? 3 : 2));
            out_ready = ($urandom_range(0, 3) < (p == 1 ? 1 : p + 1));
            in_of     = ($urandom_range(0, 7) == 0);
            in_sum    = $urandom;
            tick();
            check_model($sformatf("rand%0d", p));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/add_result_fifo.md
Name: add_result_fifo

Overview:
- Downstream consumer of the 32-bit adder stage; runs in the PLL output clock domain.
- Captures each {overflow, sum} result presented by the adder into a small synchronous FIFO.
- Presents stored results to the next stage over a valid/ready handshake.
- Holds itself in reset while the PLL is unlocked and keeps saturating statistics on overflows and dropped results.

Parameters:
- DATA_W, 32, width of sum data.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of statistics counters.

Ports:
- outclk_0  input  1  clock (PLL output clock).
- rst  input  1  synchronous, active-high reset.
- locked  input  1  PLL lock; low is treated as reset.
- in_valid  input  1  adder result valid this cycle.
- in_sum  input  DATA_W  adder result.
- in_of  input  1  adder overflow flag for in_sum.
- in_ready  output  1  FIFO can accept a result.
- out_valid  output  1  head entry available.
- out_sum  output  DATA_W  head entry sum.
- out_of  output  1  head entry overflow flag.
- out_ready  input  1  downstream accepts head entry.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- of_cnt  output  CNT_W  count of results flagged overflow.
- drop_cnt  output  CNT_W  count of results lost because FIFO full.

Behaviour:
Reset
- Effective reset is (rst || !locked), sampled on posedge outclk_0; no asynchronous path.
- On effective reset: read/write pointers = 0, level = 0, out_valid = 0, in_ready = 0, of_cnt = 0, drop_cnt = 0.
- out_sum/out_of are don't-care while out_valid = 0; the bench must not check them then.
- Stored contents are discarded.
- Reset mid-operation, including during a simultaneous push/pop, wins over everything.

Status and state
- in_ready = !full && !effective_reset, registered.
- State derived from level: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
- EMPTY -> PARTIAL on push.
- PARTIAL -> FULL on push without pop at level DEPTH-1.
- FULL -> PARTIAL on pop.
- PARTIAL -> EMPTY on pop without push at level 1.

Push and pop
- Push: in_valid && in_ready. Writes {in_of, in_sum} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Pop: out_valid && out_ready. Advances rd_ptr modulo DEPTH.
- Latency: a result pushed in cycle N is visible at out_* with out_valid = 1 in cycle N+1. No fall-through in the same cycle.
- Simultaneous push and pop in PARTIAL: both occur, level unchanged.
- When FULL: in_ready = 0, so no push is accepted even if a pop happens in the same cycle. in_ready rises the cycle after the pop.
- When EMPTY: out_valid = 0, so there is no pop.
- out_sum/out_of hold steady while out_valid && !out_ready.

Statistics
- drop_cnt increments when in_valid && !in_ready && !effective_reset.
- of_cnt increments on every accepted push with in_of = 1.
- Both counters saturate at all-ones and never wrap.

Optional Feature:
- Macro ADD_RESULT_OF_FILTER_EN.
- Defined: results with in_of = 1 are consumed (not written, not counted in drop_cnt), still increment of_cnt, and in_ready is unaffected. Only non-overflow results reach the FIFO; out_of is tied 0.
- Undefined: overflow results are stored like any other and out_of reflects the stored flag.

Decomposition:
- Package add_result_pkg holds:
  - DATA_W default constant.
  - Entry typedef {of, sum} of DATA_W+1 bits.
  - Saturating-increment function for CNT_W counters.
  - FIFO state enum {EMPTY, PARTIAL, FULL}.
- One sub-module, add_result_ram: DEPTH x (DATA_W+1) register array with one synchronous write port and one combinational read port at rd_ptr.
- Pointer, level and statistics logic stay in add_result_fifo.

Test Plan:
- Single result: reset 2 cycles with locked = 1, push in_sum = 32'h0000_0005, in_of = 0 with out_ready = 0 -> next cycle out_valid = 1, out_sum = 5, level = 1; assert out_ready -> following cycle out_valid = 0, level = 0.
- Fill/drop: push 10 consecutive values 1..10 with out_ready = 0, DEPTH = 8 -> in_ready = 0 after 8th accept, level = 8, drop_cnt = 2; drain -> outputs 1..8 in order, no 9/10.
- Wrap and concurrency: hold level = 4, then push and pop every cycle for 20 cycles -> level stays 4, output sequence exactly matches input order across pointer wrap.
- Overflow flag: push 32'h7FFF_FFFF with in_of = 1 -> of_cnt = 1. Without the macro out_of = 1 at head; with ADD_RESULT_OF_FILTER_EN level stays 0 and out_valid stays 0.
- Lock loss: with level = 5, drive locked = 0 for one cycle -> next edge level = 0, out_valid = 0, in_ready = 0, counters = 0; in_ready returns 1 the cycle after locked = 1.
- Saturation: with CNT_W = 4, cause 20 drops -> drop_cnt = 4'hF and holds.
